reg_alu_pipe: RTL and testbench

//  Parametrised register-file + ALU execution unit: NREGS x DATA_W register file, 8-op ALU, 2-stage pipeline.
//  - Accepts one instruction per cycle over valid/ready, executes it and writes the result back to the register file.
//  - Reports result and flags on a result port.
//  - Replaces hand-sequenced register_file/ALU control with a self-contained datapath slice.

---
 rtl/reg_alu_pkg.sv | 20 ++
 rtl/reg_alu_core.sv | 50 +++++
 rtl/reg_alu_pipe.sv | 138 +++++++++++++
 tb/tb_reg_alu_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_alu_pkg.sv
// Shared opcode encodings and flag type for the register-file + ALU execution slice.
package reg_alu_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_LDI = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD = 3'd1;
    localparam logic [OP_W-1:0] OP_SUB = 3'd2;
    localparam logic [OP_W-1:0] OP_AND = 3'd3;
    localparam logic [OP_W-1:0] OP_OR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR = 3'd5;
    localparam logic [OP_W-1:0] OP_SHL = 3'd6;
    localparam logic [OP_W-1:0] OP_SHR = 3'd7;

    typedef struct packed {
        logic carry;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/reg_alu_core.sv
// Purely combinational 8-op ALU: opcode, operands and immediate in; result, carry and zero out.
module reg_alu_core
    import reg_alu_pkg::*;
#(
    parameter int unsigned DATA_W = 12
) (
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] result_o,
    output alu_flags_t        flags_o
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [SH_W-1:0]   shamt;
    logic              shift_ovf;

    assign sum       = {1'b0, a_i} + {1'b0, b_i};
    // Zero-extended subtraction: the top bit is the unsigned borrow (a < b).
    assign diff      = {1'b0, a_i} - {1'b0, b_i};
    assign shamt     = b_i[SH_W-1:0];
    assign shift_ovf = (32'(shamt) >= DATA_W);

    always_comb begin
        result_o      = '0;
        flags_o.carry = 1'b0;
        unique case (op_i)
            OP_LDI: result_o = imm_i;
            OP_ADD: begin
                result_o      = sum[DATA_W-1:0];
                flags_o.carry = sum[DATA_W];
            end
            OP_SUB: begin
                result_o      = diff[DATA_W-1:0];
                flags_o.carry = diff[DATA_W];
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_SHL: result_o = shift_ovf ? '0 : (a_i << shamt);
            OP_SHR: result_o = shift_ovf ? '0 : (a_i >> shamt);
        endcase
        flags_o.zero = (result_o == '0);
    end

endmodule

// File: rtl/reg_alu_pipe.sv
// Register file + ALU execution unit with a 2-stage (X, writeback) pipeline.
// Define REG_ALU_FWD_EN to forward the X-stage result instead of stalling on a hazard.
module reg_alu_pipe
    import reg_alu_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned NREGS  = 8,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [AW-1:0]     in_rd,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
    input  logic [DATA_W-1:0] in_imm,
    output logic              res_valid,
    output logic [AW-1:0]     res_rd,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry,
    output logic              res_zero,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic              x_valid_q, x_valid_d;
    logic [AW-1:0]     x_rd_q, x_rd_d;
    logic [DATA_W-1:0] x_data_q, x_data_d;
    alu_flags_t        x_flags_q, x_flags_d;

    logic              res_valid_q, res_valid_d;
    logic [AW-1:0]     res_rd_q, res_rd_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    alu_flags_t        res_flags_q, res_flags_d;

    logic              accept;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    alu_flags_t        alu_flags;

`ifdef REG_ALU_FWD_EN
    // The X stage holds the only not-yet-written result, so bypassing it resolves every hazard.
    always_comb begin
        in_ready = rst_n;
        op_a     = (x_valid_q && (x_rd_q == in_rs1)) ? x_data_q : regs_q[in_rs1];
        op_b     = (x_valid_q && (x_rd_q == in_rs2)) ? x_data_q : regs_q[in_rs2];
    end
`else
    logic uses_rs;
    logic hazard;

    always_comb begin
        uses_rs  = (in_op != OP_LDI);
        hazard   = x_valid_q && uses_rs && ((x_rd_q == in_rs1) || (x_rd_q == in_rs2));
        in_ready = rst_n && !hazard;
        op_a     = regs_q[in_rs1];
        op_b     = regs_q[in_rs2];
    end
`endif

    assign accept = in_valid && in_ready;

    reg_alu_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .op_i     (in_op),
        .a_i      (op_a),
        .b_i      (op_b),
        .imm_i    (in_imm),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    always_comb begin
        regs_d = regs_q;
        if (x_valid_q) begin
            regs_d[x_rd_q] = x_data_q;
        end

        x_valid_d = accept;
        x_rd_d    = x_rd_q;
        x_data_d  = x_data_q;
        x_flags_d = x_flags_q;
        if (accept) begin
            x_rd_d    = in_rd;
            x_data_d  = alu_result;
            x_flags_d = alu_flags;
        end

        res_valid_d = x_valid_q;
        res_rd_d    = res_rd_q;
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        if (x_valid_q) begin
            res_rd_d    = x_rd_q;
            res_data_d  = x_data_q;
            res_flags_d = x_flags_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q      <= '{default: '0};
            x_valid_q   <= 1'b0;
            x_rd_q      <= '0;
            x_data_q    <= '0;
            x_flags_q   <= '0;
            res_valid_q <= 1'b0;
            res_rd_q    <= '0;
            res_data_q  <= '0;
            res_flags_q <= '0;
        end else begin
            regs_q      <= regs_d;
            x_valid_q   <= x_valid_d;
            x_rd_q      <= x_rd_d;
            x_data_q    <= x_data_d;
            x_flags_q   <= x_flags_d;
            res_valid_q <= res_valid_d;
            res_rd_q    <= res_rd_d;
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_rd    = res_rd_q;
    assign res_data  = res_data_q;
    assign res_carry = res_flags_q.carry;
    assign res_zero  = res_flags_q.zero;
    assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Directed + short randomised self-checking bench for reg_alu_pipe (DATA_W=12, NREGS=8).
module tb_reg_alu_pipe;
    import reg_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic [11:0] in_imm;
    logic        res_valid;
    logic [2:0]  res_rd;
    logic [11:0] res_data;
    logic        res_carry;
    logic        res_zero;
    logic [2:0]  dbg_addr;
    logic [11:0] dbg_data;

    typedef struct packed {
        logic [2:0]  rd;
        logic [11:0] data;
        logic        carry;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] mdl [8];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          st;

`ifdef REG_ALU_FWD_EN
    localparam int HAZ_STALLS = 0;
`else
    localparam int HAZ_STALLS = 1;
`endif

    reg_alu_pipe #(
        .DATA_W (12),
        .NREGS  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .res_valid (res_valid),
        .res_rd    (res_rd),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_zero  (res_zero),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: returns {carry, data}.
    function automatic logic [12:0] model(input logic [2:0] op, input logic [11:0] a,
                                          input logic [11:0] b, input logic [11:0] imm);
        logic [12:0] r;
        r = '0;
        case (op)
            OP_LDI: r[11:0] = imm;
            OP_ADD: r = {1'b0, a} + {1'b0, b};
            OP_SUB: begin r[11:0] = a - b; r[12] = (a < b); end
            OP_AND: r[11:0] = a & b;
            OP_OR:  r[11:0] = a | b;
            OP_XOR: r[11:0] = a ^ b;
            OP_SHL: r[11:0] = (b[3:0] >= 4'd12) ? 12'h000 : (a << b[3:0]);
            default: r[11:0] = (b[3:0] >= 4'd12) ? 12'h000 : (a >> b[3:0]);
        endcase
        return r;
    endfunction

    // Present one instruction, wait (bounded) for acceptance; returns at accept edge + 1.
    task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [11:0] imm, output int stalls);
        logic [12:0] r;
        bit ok;
        ok = 0;
        stalls = 0;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
            stalls++;
        end
        if (!ok) begin
            check_eq("ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        r = model(op, mdl[rs1], mdl[rs2], imm);
        mdl[rd] = r[11:0];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic exec(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [11:0] imm,
                        input logic [11:0] exp_data, input logic exp_carry, output int stalls);
        exp_q.push_back('{rd: rd, data: exp_data, carry: exp_carry});
        send(op, rd, rs1, rs2, imm, stalls);
    endtask

    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_res", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("res_rd", 32'(res_rd), 32'(e.rd));
                check_eq("res_data", 32'(res_data), 32'(e.data));
                check_eq("res_carry", 32'(res_carry), 32'(e.carry));
                check_eq("res_zero", 32'(res_zero), 32'(e.data == 12'h000));
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; dbg_addr = '0;
        for (int i = 0; i < 8; i++) mdl[i] = '0;

        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(in_ready), 0);
        check_eq("rst_res_valid", 32'(res_valid), 0);
        check_eq("rst_res_data", 32'(res_data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("ready_after_rst", 32'(in_ready), 1);

        // 1: reset with instructions in flight
        send(OP_LDI, 3'd3, 3'd0, 3'd0, 12'h123, st);
        send(OP_LDI, 3'd4, 3'd0, 3'd0, 12'h456, st);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_ready", 32'(in_ready), 0);
        check_eq("midrst_res_valid", 32'(res_valid), 0);
        check_eq("midrst_res_rd", 32'(res_rd), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check_eq("rst_regfile", 32'(dbg_data), 0);
        end
        repeat (3) begin
            @(negedge clk);
            check_eq("no_late_res", 32'(res_valid), 0);
        end
        @(posedge clk); #1;

        // 2: basic ops
        exec(OP_LDI, 3'd0, 3'd0, 3'd0, 12'hF7C, 12'hF7C, 1'b0, st);
        exec(OP_LDI, 3'd1, 3'd0, 3'd0, 12'h002, 12'h002, 1'b0, st);
        check_eq("ldi_no_stall", st, 0);
        exec(OP_ADD, 3'd2, 3'd0, 3'd1, 12'h000, 12'hF7E, 1'b0, st);
        exec(OP_SUB, 3'd3, 3'd0, 3'd1, 12'h000, 12'hF7A, 1'b0, st);
        exec(OP_AND, 3'd4, 3'd0, 3'd1, 12'h000, 12'h000, 1'b0, st);
        exec(OP_OR,  3'd4, 3'd0, 3'd1, 12'h000, 12'hF7E, 1'b0, st);

        // 3: carry / borrow / zero
        exec(OP_LDI, 3'd5, 3'd0, 3'd0, 12'h440, 12'h440, 1'b0, st);
        exec(OP_LDI, 3'd6, 3'd0, 3'd0, 12'h440, 12'h440, 1'b0, st);
        exec(OP_ADD, 3'd7, 3'd5, 3'd6, 12'h000, 12'h880, 1'b0, st);
        exec(OP_SUB, 3'd7, 3'd5, 3'd6, 12'h000, 12'h000, 1'b0, st);
        exec(OP_SUB, 3'd2, 3'd1, 3'd0, 12'h000, 12'h086, 1'b1, st);
        exec(OP_LDI, 3'd5, 3'd0, 3'd0, 12'hFFF, 12'hFFF, 1'b0, st);
        exec(OP_LDI, 3'd6, 3'd0, 3'd0, 12'h001, 12'h001, 1'b0, st);
        exec(OP_ADD, 3'd7, 3'd5, 3'd6, 12'h000, 12'h000, 1'b1, st);

        // debug port shows the old value while the write is pending
        exec(OP_LDI, 3'd5, 3'd0, 3'd0, 12'h0AA, 12'h0AA, 1'b0, st);
        dbg_addr = 3'd5;
        @(negedge clk);
        check_eq("dbg_old_value", 32'(dbg_data), 32'h0FFF);
        @(negedge clk);
        check_eq("dbg_new_value", 32'(dbg_data), 32'h00AA);
        @(posedge clk); #1;

        // 4: back-to-back RAW hazard
        exec(OP_LDI, 3'd1, 3'd0, 3'd0, 12'h005, 12'h005, 1'b0, st);
        exec(OP_ADD, 3'd2, 3'd1, 3'd1, 12'h000, 12'h00A, 1'b0, st);
        check_eq("hazard_stalls", st, HAZ_STALLS);

        // 5: shifts and xor
        exec(OP_LDI, 3'd1, 3'd0, 3'd0, 12'h002, 12'h002, 1'b0, st);
        exec(OP_SHL, 3'd3, 3'd0, 3'd1, 12'h000, 12'hDF0, 1'b0, st);
        exec(OP_SHR, 3'd3, 3'd0, 3'd1, 12'h000, 12'h3DF, 1'b0, st);
        exec(OP_LDI, 3'd2, 3'd0, 3'd0, 12'h00C, 12'h00C, 1'b0, st);
        exec(OP_SHR, 3'd3, 3'd0, 3'd2, 12'h000, 12'h000, 1'b0, st);
        exec(OP_LDI, 3'd2, 3'd0, 3'd0, 12'h00D, 12'h00D, 1'b0, st);
        exec(OP_SHL, 3'd4, 3'd0, 3'd2, 12'h000, 12'h000, 1'b0, st);
        exec(OP_XOR, 3'd3, 3'd0, 3'd0, 12'h000, 12'h000, 1'b0, st);

        // 6: short random stream against the model
        for (int n = 0; n < 300; n++) begin
            logic [2:0]  op, rd, rs1, rs2;
            logic [11:0] imm;
            logic [12:0] r;
            op  = 3'($urandom_range(0, 7));
            rd  = 3'($urandom_range(0, 7));
            rs1 = 3'($urandom_range(0, 7));
            rs2 = 3'($urandom_range(0, 7));
            imm = 12'($urandom);
            r   = model(op, mdl[rs1], mdl[rs2], imm);
            exp_q.push_back('{rd: rd, data: r[11:0], carry: r[12]});
            send(op, rd, rs1, rs2, imm, st);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        check_eq("drain", exp_q.size(), 0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check_eq("final_regfile", 32'(dbg_data), 32'(mdl[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
